// File: rtl/uart_echo_fifo.sv
// UART echo bridge: oversampling receiver -> FIFO -> transmitter.
// Each good character is queued and sent back on o_tx. Bad frames, bad
// parity and characters that find the FIFO full are reported by one-cycle pulses.
module uart_echo_fifo #(
    parameter int CLOCK      = 125000000,
    parameter int BAUDRATE   = 115200,
    parameter int OSR        = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int INVERT_RX  = 1,
    parameter int INVERT_TX  = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_rx,
    output logic                            o_tx,
    input  logic                            i_en,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
    output logic                            o_overrun,
    output logic                            o_parity_err,
    output logic                            o_frame_err
);

    localparam int DIV_RAW  = CLOCK / (OSR * BAUDRATE);
    localparam int DIVIDER  = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W    = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int RXC_W    = $clog2(OSR + 1);
    localparam int STOP_LEN = STOP_BITS * OSR;
    localparam int TXC_W    = $clog2(STOP_LEN);
    localparam int BIT_W    = $clog2(DATA_BITS);

    localparam logic RX_INV      = (INVERT_RX != 0);
    localparam logic TX_INV      = (INVERT_TX != 0);
    localparam logic RX_IDLE_RAW = ~RX_INV;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ---------------- tick generator ----------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(DIVIDER - 1));

    // Free-running divider producing one tick every DIVIDER clocks.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

    // ---------------- receiver ----------------
    logic [1:0]           rx_sync;
    logic                 rxs;
    state_t               rx_state;
    logic [RXC_W-1:0]     rx_cnt;
    logic [BIT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par;
    logic                 par_bad;
    logic                 push_req;

    // Two-flop synchroniser, preset to the idle line level so reset looks idle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) rx_sync <= {2{RX_IDLE_RAW}};
        else        rx_sync <= {rx_sync[0], i_rx};
    end

    assign rxs = rx_sync[1] ^ RX_INV;

    // Parity check against the assembled character; never fails without parity.
    always_comb begin
        par_bad = 1'b0;
        if (PARITY == 1)      par_bad = ~(^rx_shift ^ rx_par);
        else if (PARITY == 2) par_bad = ^rx_shift ^ rx_par;
    end

    // Receive FSM: mid-bit sampling, verdict registered one cycle after the stop sample.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_state     <= ST_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_par       <= 1'b0;
            push_req     <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            push_req     <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            if (tick) begin
                case (rx_state)
                    ST_IDLE: begin
                        if (!rxs) begin
                            rx_state <= ST_START;
                            rx_cnt   <= RXC_W'(1);
                        end
                    end
                    ST_START: begin
                        if (rx_cnt == RXC_W'(OSR / 2)) begin
                            rx_cnt <= RXC_W'(1);
                            rx_bit <= '0;
                            if (rxs) rx_state <= ST_IDLE;
                            else     rx_state <= ST_DATA;
                        end else begin
                            rx_cnt <= rx_cnt + RXC_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (rx_cnt == RXC_W'(OSR)) begin
                            rx_cnt   <= RXC_W'(1);
                            rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
                            if (rx_bit == BIT_W'(DATA_BITS - 1)) begin
                                if (PARITY != 0) rx_state <= ST_PARITY;
                                else             rx_state <= ST_STOP;
                            end else begin
                                rx_bit <= rx_bit + BIT_W'(1);
                            end
                        end else begin
                            rx_cnt <= rx_cnt + RXC_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        if (rx_cnt == RXC_W'(OSR)) begin
                            rx_cnt   <= RXC_W'(1);
                            rx_par   <= rxs;
                            rx_state <= ST_STOP;
                        end else begin
                            rx_cnt <= rx_cnt + RXC_W'(1);
                        end
                    end
                    ST_STOP: begin
                        if (rx_cnt == RXC_W'(OSR)) begin
                            rx_cnt   <= RXC_W'(1);
                            rx_state <= ST_IDLE;
                            if (!rxs)        o_frame_err  <= 1'b1;
                            else if (par_bad) o_parity_err <= 1'b1;
                            else              push_req     <= 1'b1;
                        end else begin
                            rx_cnt <= rx_cnt + RXC_W'(1);
                        end
                    end
                    default: rx_state <= ST_IDLE;
                endcase
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    // Full is judged on the current occupancy, so a same-cycle pop does not rescue a push.
    assign full      = (o_count == CNT_W'(FIFO_DEPTH));
    assign push      = push_req & ~full;
    assign o_overrun = push_req & full;
    assign head      = mem[rd_ptr];
    assign head_par  = (PARITY == 1) ? ~(^head) : (^head);

    // Storage array; contents are meaningless once occupancy is cleared.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= rx_shift;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   o_count <= o_count + CNT_W'(1);
                2'b01:   o_count <= o_count - CNT_W'(1);
                default: o_count <= o_count;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    state_t               tx_state;
    logic [TXC_W-1:0]     tx_cnt;
    logic [BIT_W-1:0]     tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;

    // A new frame starts from idle or on the final stop tick, so queued frames run back-to-back.
    assign pop = tick & i_en & (o_count != '0) &
                 ((tx_state == ST_IDLE) ||
                  ((tx_state == ST_STOP) && (tx_cnt == TXC_W'(STOP_LEN - 1))));

    // Transmit FSM with registered line output.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            o_tx     <= 1'b1 ^ TX_INV;
        end else if (tick) begin
            if (pop) begin
                tx_shift <= head;
                tx_par   <= head_par;
                tx_cnt   <= '0;
                tx_bit   <= '0;
                tx_state <= ST_START;
                o_tx     <= 1'b0 ^ TX_INV;
            end else begin
                case (tx_state)
                    ST_IDLE: o_tx <= 1'b1 ^ TX_INV;
                    ST_START: begin
                        if (tx_cnt == TXC_W'(OSR - 1)) begin
                            tx_cnt   <= '0;
                            tx_state <= ST_DATA;
                            o_tx     <= tx_shift[0] ^ TX_INV;
                        end else begin
                            tx_cnt <= tx_cnt + TXC_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (tx_cnt == TXC_W'(OSR - 1)) begin
                            tx_cnt <= '0;
                            if (tx_bit == BIT_W'(DATA_BITS - 1)) begin
                                if (PARITY != 0) begin
                                    tx_state <= ST_PARITY;
                                    o_tx     <= tx_par ^ TX_INV;
                                end else begin
                                    tx_state <= ST_STOP;
                                    o_tx     <= 1'b1 ^ TX_INV;
                                end
                            end else begin
                                tx_bit   <= tx_bit + BIT_W'(1);
                                tx_shift <= tx_shift >> 1;
                                o_tx     <= tx_shift[1] ^ TX_INV;
                            end
                        end else begin
                            tx_cnt <= tx_cnt + TXC_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        if (tx_cnt == TXC_W'(OSR - 1)) begin
                            tx_cnt   <= '0;
                            tx_state <= ST_STOP;
                            o_tx     <= 1'b1 ^ TX_INV;
                        end else begin
                            tx_cnt <= tx_cnt + TXC_W'(1);
                        end
                    end
                    ST_STOP: begin
                        if (tx_cnt == TXC_W'(STOP_LEN - 1)) begin
                            tx_cnt   <= '0;
                            tx_state <= ST_IDLE;
                        end else begin
                            tx_cnt <= tx_cnt + TXC_W'(1);
                        end
                    end
                    default: tx_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: three instances (plain 8N1 depth 4, even parity,
// inverted lines with two stop bits), a vector table plus corner sequences.
module tb_uart_echo_fifo;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] rx;
    logic [2:0] en;
    logic tx_w [3];
    logic ov_w [3];
    logic pe_w [3];
    logic fe_w [3];
    logic [2:0] count_a;
    logic [2:0] count_b;
    logic [4:0] count_c;

    // Clock: 16 clocks per bit with DIVIDER = 1.
    always #5 clk = ~clk;

    uart_echo_fifo #(.CLOCK(1843200), .BAUDRATE(115200), .OSR(16), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .INVERT_RX(0), .INVERT_TX(0)) u_a (
        .i_clk(clk), .i_rst(rst_n), .i_rx(rx[0]), .o_tx(tx_w[0]), .i_en(en[0]),
        .o_count(count_a), .o_overrun(ov_w[0]), .o_parity_err(pe_w[0]), .o_frame_err(fe_w[0]));

    uart_echo_fifo #(.CLOCK(1843200), .BAUDRATE(115200), .OSR(16), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4), .INVERT_RX(0), .INVERT_TX(0)) u_b (
        .i_clk(clk), .i_rst(rst_n), .i_rx(rx[1]), .o_tx(tx_w[1]), .i_en(en[1]),
        .o_count(count_b), .o_overrun(ov_w[1]), .o_parity_err(pe_w[1]), .o_frame_err(fe_w[1]));

    uart_echo_fifo #(.CLOCK(1843200), .BAUDRATE(115200), .OSR(16), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16), .INVERT_RX(1), .INVERT_TX(1)) u_c (
        .i_clk(clk), .i_rst(rst_n), .i_rx(rx[2]), .o_tx(tx_w[2]), .i_en(en[2]),
        .o_count(count_c), .o_overrun(ov_w[2]), .o_parity_err(pe_w[2]), .o_frame_err(fe_w[2]));

    // ---------------- scoreboard counters ----------------
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ov_n [3] = '{0, 0, 0};
    int pe_n [3] = '{0, 0, 0};
    int fe_n [3] = '{0, 0, 0};
    int act_n [3] = '{0, 0, 0};
    int push_cyc [3] = '{0, 0, 0};
    int prev_cnt [3] = '{0, 0, 0};

    function automatic int count_of(input int i);
        case (i)
            0:       return int'(count_a);
            1:       return int'(count_b);
            default: return int'(count_c);
        endcase
    endfunction

    // Logical line level (instance 2 drives an inverted line).
    function automatic logic line_of(input int i);
        case (i)
            0:       return tx_w[0];
            1:       return tx_w[1];
            default: return ~tx_w[2];
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse, line-activity and push monitors sampled on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ov_w[i]) ov_n[i]++;
            if (pe_w[i]) pe_n[i]++;
            if (fe_w[i]) fe_n[i]++;
            if (line_of(i) == 1'b0) act_n[i]++;
            if (count_of(i) > prev_cnt[i]) push_cyc[i] = cyc;
            prev_cnt[i] = count_of(i);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_rx(input int inst, input logic v);
        case (inst)
            0:       rx[0] = v;
            1:       rx[1] = v;
            default: rx[2] = ~v;
        endcase
    endtask

    // Sends one frame with a single stop bit; instance 1 also carries a parity bit.
    task automatic send_frame(input int inst, input logic [7:0] d, input logic par, input logic stop);
        logic [11:0] w;
        int n;
        if (inst == 1) begin
            w = {1'b0, stop, par, d, 1'b0};
            n = 11;
        end else begin
            w = {2'b00, stop, d, 1'b0};
            n = 10;
        end
        for (int i = 0; i < n; i++) begin
            set_rx(inst, w[i]);
            repeat (16) @(negedge clk);
        end
        set_rx(inst, 1'b1);
    endtask

    // Waits (bounded) for a start bit on the echo line and samples each bit centre.
    task automatic capture(input int inst, input int n, output logic [11:0] word,
                           output int start_cyc, output bit ok);
        ok = 1'b0;
        word = '0;
        start_cyc = -1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (line_of(inst) == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            start_cyc = cyc;
            repeat (8) @(negedge clk);
            word[0] = line_of(inst);
            for (int i = 1; i < n; i++) begin
                repeat (16) @(negedge clk);
                word[i] = line_of(inst);
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          inst;
        logic [7:0]  data;
        logic        par;
        logic        stop;
        logic        echo;
        logic [11:0] exp_word;
        int          n;
        int          exp_pe;
        int          exp_fe;
    } vec_t;

    vec_t vecs [12];

    task automatic run_vec(input int k);
        vec_t v;
        logic [11:0] word;
        int st;
        bit ok;
        int s_ov, s_pe, s_fe, s_act;
        v = vecs[k];
        s_ov = ov_n[v.inst];
        s_pe = pe_n[v.inst];
        s_fe = fe_n[v.inst];
        s_act = act_n[v.inst];
        if (v.echo) begin
            fork
                send_frame(v.inst, v.data, v.par, v.stop);
                capture(v.inst, v.n, word, st, ok);
            join
            check($sformatf("v%0d_echo_seen", k), int'(ok), 1);
            check($sformatf("v%0d_echo_word", k), int'(word), int'(v.exp_word));
            if (k == 0) check("v0_push_to_start_1to3", int'((st - push_cyc[0]) >= 1 && (st - push_cyc[0]) <= 3), 1);
            repeat (40) @(negedge clk);
        end else begin
            send_frame(v.inst, v.data, v.par, v.stop);
            repeat (60) @(negedge clk);
            check($sformatf("v%0d_no_echo", k), act_n[v.inst] - s_act, 0);
        end
        check($sformatf("v%0d_parity_err", k), pe_n[v.inst] - s_pe, v.exp_pe);
        check($sformatf("v%0d_frame_err", k), fe_n[v.inst] - s_fe, v.exp_fe);
        check($sformatf("v%0d_overrun", k), ov_n[v.inst] - s_ov, 0);
        check($sformatf("v%0d_count", k), count_of(v.inst), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [11:0] word;
        logic [11:0] exp_words [4];
        int st, prev_st, st1, s_act, s_ov, s_pe, s_fe;
        bit ok;

        rst_n = 1'b0;
        rx = 3'b011;
        en = 3'b000;
        repeat (3) @(negedge clk);

        // Reset state, checked while reset is held.
        check("rst_tx_a", int'(tx_w[0]), 1);
        check("rst_tx_b", int'(tx_w[1]), 1);
        check("rst_tx_c_inverted_idle", int'(tx_w[2]), 0);
        check("rst_count_a", int'(count_a), 0);
        check("rst_count_c", int'(count_c), 0);
        check("rst_pulses_a", int'({ov_w[0], pe_w[0], fe_w[0]}), 0);
        rst_n = 1'b1;
        en = 3'b111;
        repeat (5) @(negedge clk);

        vecs[0]  = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 12'h34A, 10, 0, 0};
        vecs[1]  = '{0, 8'h5A, 1'b0, 1'b1, 1'b1, 12'h2B4, 10, 0, 0};
        vecs[2]  = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 12'h200, 10, 0, 0};
        vecs[3]  = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 12'h3FE, 10, 0, 0};
        vecs[4]  = '{0, 8'h3C, 1'b0, 1'b0, 1'b0, 12'h000, 10, 0, 1};
        vecs[5]  = '{1, 8'h03, 1'b1, 1'b1, 1'b0, 12'h000, 11, 1, 0};
        vecs[6]  = '{1, 8'h03, 1'b0, 1'b1, 1'b1, 12'h406, 11, 0, 0};
        vecs[7]  = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 12'h60E, 11, 0, 0};
        vecs[8]  = '{1, 8'h07, 1'b0, 1'b1, 1'b0, 12'h000, 11, 1, 0};
        vecs[9]  = '{1, 8'h03, 1'b1, 1'b0, 1'b0, 12'h000, 11, 0, 1};
        vecs[10] = '{2, 8'h3C, 1'b0, 1'b1, 1'b1, 12'h678, 11, 0, 0};
        vecs[11] = '{2, 8'hC3, 1'b0, 1'b1, 1'b1, 12'h786, 11, 0, 0};

        for (int k = 0; k < 12; k++) run_vec(k);

        // Buffering and overrun with transmit gated off.
        en[0] = 1'b0;
        exp_words[0] = 12'h202;
        exp_words[1] = 12'h204;
        exp_words[2] = 12'h206;
        exp_words[3] = 12'h208;
        s_ov = ov_n[0];
        for (int c = 1; c <= 5; c++) begin
            send_frame(0, 8'(c), 1'b0, 1'b1);
            repeat (4) @(negedge clk);
            if (c == 4) begin
                check("buf_count_after_4", int'(count_a), 4);
                check("buf_no_overrun_yet", ov_n[0] - s_ov, 0);
            end
        end
        check("buf_overrun_on_5th", ov_n[0] - s_ov, 1);
        check("buf_count_still_4", int'(count_a), 4);
        en[0] = 1'b1;
        prev_st = 0;
        for (int f = 0; f < 4; f++) begin
            capture(0, 10, word, st, ok);
            check($sformatf("buf_echo%0d_seen", f), int'(ok), 1);
            check($sformatf("buf_echo%0d_word", f), int'(word), int'(exp_words[f]));
            if (f > 0) check($sformatf("buf_b2b_spacing%0d", f), st - prev_st, 160);
            prev_st = st;
        end
        s_act = act_n[0];
        repeat (200) @(negedge clk);
        check("buf_no_fifth_echo", act_n[0] - s_act, 0);
        check("buf_count_drained", int'(count_a), 0);

        // Inverted lines, two stop bits: stop phase between queued frames.
        en[2] = 1'b0;
        send_frame(2, 8'h3C, 1'b0, 1'b1);
        send_frame(2, 8'h81, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("inv_count_2", int'(count_c), 2);
        en[2] = 1'b1;
        capture(2, 11, word, st1, ok);
        check("inv_frame1_word", int'(word), 12'h678);
        capture(2, 11, word, st, ok);
        check("inv_frame2_seen", int'(ok), 1);
        check("inv_frame2_word", int'(word), 12'h702);
        check("inv_stop_phase_clocks", st - (st1 + 9 * 16), 32);
        repeat (60) @(negedge clk);
        check("inv_idle_raw_low", int'(tx_w[2]), 0);

        // Short low glitch must be rejected without any reaction.
        s_act = act_n[0];
        s_ov = ov_n[0];
        s_pe = pe_n[0];
        s_fe = fe_n[0];
        set_rx(0, 1'b0);
        repeat (5) @(negedge clk);
        set_rx(0, 1'b1);
        repeat (100) @(negedge clk);
        check("glitch_no_tx", act_n[0] - s_act, 0);
        check("glitch_no_frame_err", fe_n[0] - s_fe, 0);
        check("glitch_no_parity_err", pe_n[0] - s_pe, 0);
        check("glitch_no_overrun", ov_n[0] - s_ov, 0);
        check("glitch_count", int'(count_a), 0);

        // Reset in the middle of a transmitted frame with two entries still queued.
        en[0] = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        send_frame(0, 8'h33, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("rstmid_count_3", int'(count_a), 3);
        en[0] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (line_of(0) == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("rstmid_start_seen", int'(ok), 1);
        repeat (8 + 4 * 16) @(negedge clk);
        check("rstmid_bit3_level", int'(tx_w[0]), 0);
        check("rstmid_queued_2", int'(count_a), 2);
        rst_n = 1'b0;
        #1;
        check("rstmid_tx_idle_async", int'(tx_w[0]), 1);
        check("rstmid_count_cleared", int'(count_a), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        s_act = act_n[0];
        repeat (300) @(negedge clk);
        check("rstmid_no_activity", act_n[0] - s_act, 0);
        check("rstmid_count_after", int'(count_a), 0);
        fork
            send_frame(0, 8'h5A, 1'b0, 1'b1);
            capture(0, 10, word, st, ok);
        join
        check("rstmid_recover_seen", int'(ok), 1);
        check("rstmid_recover_word", int'(word), 12'h2B4);
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
